// File: rtl/sysid_probe_pkg.sv
// Shared types and constants for the system-ID probe master.
// Holds the FSM state encoding and the slave word offsets.
package sysid_probe_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ID_REQ,
    ID_WAIT,
    TS_REQ,
    TS_WAIT,
    DONE
  } state_t;

  localparam int SYSID_OFS_ID = 0;
  localparam int SYSID_OFS_TS = 1;

endpackage

// File: rtl/sysid_probe_timer.sv
// Per-word response timer for the system-ID probe master.
// Counts cycles while enabled; expired flags the last allowed cycle.
module sysid_probe_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] count;

  // Clear takes priority so each word starts counting from zero
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/sysid_probe_master.sv
// Avalon-MM read master that fetches the system-ID and timestamp
// words after boot and compares them against build-time values.
module sysid_probe_master
  import sysid_probe_pkg::*;
#(
  parameter logic [31:0] EXP_ID         = 32'd0,
  parameter logic [31:0] EXP_TIMESTAMP  = 32'd1537788542,
  parameter int          ADDR_W         = 1,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] av_address,
  output logic              av_read,
  input  logic              av_waitrequest,
  input  logic [31:0]       av_readdata,
  input  logic              av_readdatavalid,
  output logic              busy,
  output logic              done,
  output logic [31:0]       id_value,
  output logic [31:0]       ts_value,
  output logic              id_match,
  output logic              ts_match,
  output logic              timeout
);

  state_t state;
  logic   in_req;
  logic   in_wait;
  logic   accept;
  logic   capture;
  logic   expired;
  logic   tmr_en;
  logic   tmr_clear;

  // Bus handshake decode; a response only counts for an accepted read
  always_comb begin
    in_req    = (state == ID_REQ) || (state == TS_REQ);
    in_wait   = (state == ID_WAIT) || (state == TS_WAIT);
    accept    = in_req && !av_waitrequest;
    capture   = (accept || in_wait) && av_readdatavalid;
    tmr_en    = in_req || in_wait;
    tmr_clear = !tmr_en || capture;
  end

  sysid_probe_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (tmr_clear),
    .enable  (tmr_en),
    .expired (expired)
  );

  // Probe sequencer with registered bus, status and result outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      av_address <= '0;
      av_read    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      id_value   <= '0;
      ts_value   <= '0;
      id_match   <= 1'b0;
      ts_match   <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state      <= ID_REQ;
            busy       <= 1'b1;
            av_read    <= 1'b1;
            av_address <= ADDR_W'(SYSID_OFS_ID);
            id_value   <= '0;
            ts_value   <= '0;
            id_match   <= 1'b0;
            ts_match   <= 1'b0;
            timeout    <= 1'b0;
          end
        end
        ID_REQ, ID_WAIT: begin
          if (capture) begin
            id_value   <= av_readdata;
            state      <= TS_REQ;
            av_read    <= 1'b1;
            av_address <= ADDR_W'(SYSID_OFS_TS);
          end else if (expired) begin
            state   <= DONE;
            done    <= 1'b1;
            timeout <= 1'b1;
            av_read <= 1'b0;
          end else if (accept) begin
            state   <= ID_WAIT;
            av_read <= 1'b0;
          end
        end
        TS_REQ, TS_WAIT: begin
          if (capture) begin
            ts_value <= av_readdata;
            ts_match <= (av_readdata == EXP_TIMESTAMP);
            id_match <= (id_value == EXP_ID);
            state    <= DONE;
            done     <= 1'b1;
            av_read  <= 1'b0;
          end else if (expired) begin
            state   <= DONE;
            done    <= 1'b1;
            timeout <= 1'b1;
            av_read <= 1'b0;
          end else if (accept) begin
            state   <= TS_WAIT;
            av_read <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sysid_probe_master.sv
// Bench for sysid_probe_master: behavioural Avalon slave, latency and
// result prediction from per-word stall/response delays.
module tb_sysid_probe_master;

  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1537788542;
  localparam int          T      = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [0:0]  av_address;
  logic        av_read;
  logic        av_waitrequest;
  logic [31:0] av_readdata;
  logic        av_readdatavalid;
  logic        busy;
  logic        done;
  logic [31:0] id_value;
  logic [31:0] ts_value;
  logic        id_match;
  logic        ts_match;
  logic        timeout;

  sysid_probe_master #(
    .EXP_ID         (EXP_ID),
    .EXP_TIMESTAMP  (EXP_TS),
    .ADDR_W         (1),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .av_address       (av_address),
    .av_read          (av_read),
    .av_waitrequest   (av_waitrequest),
    .av_readdata      (av_readdata),
    .av_readdatavalid (av_readdatavalid),
    .busy             (busy),
    .done             (done),
    .id_value         (id_value),
    .ts_value         (ts_value),
    .id_match         (id_match),
    .ts_match         (ts_match),
    .timeout          (timeout)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // slave configuration per word: stall cycles, response delay (-1 = never)
  int          cfg_w[2];
  int          cfg_d[2];
  logic [31:0] cfg_word[2];

  // expected results
  int          exp_off;
  int          exp_acc;
  logic [31:0] exp_id;
  logic [31:0] exp_ts;
  logic        exp_idm;
  logic        exp_tsm;
  logic        exp_to;

  int          acc_q[$];
  int          done_cnt = 0;
  int          viol = 0;
  logic        prev_stall = 1'b0;
  logic [0:0]  prev_addr = '0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Behavioural slave: stalls cfg_w cycles, answers cfg_d cycles after accept
  initial begin
    int stall;
    int pend;
    int a;
    logic [31:0] pend_data;
    stall = 0;
    pend = 0;
    pend_data = '0;
    av_waitrequest = 1'b1;
    av_readdatavalid = 1'b0;
    av_readdata = '0;
    forever begin
      @(negedge clock);
      av_readdatavalid = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          av_readdatavalid = 1'b1;
          av_readdata = pend_data;
        end
      end
      if (av_read === 1'b1) begin
        a = int'(av_address);
        if (stall < cfg_w[a]) begin
          av_waitrequest = 1'b1;
          stall++;
        end else begin
          av_waitrequest = 1'b0;
          stall = 0;
          if (cfg_d[a] == 0) begin
            av_readdatavalid = 1'b1;
            av_readdata = cfg_word[a];
          end else if (cfg_d[a] > 0) begin
            pend = cfg_d[a];
            pend_data = cfg_word[a];
          end
        end
      end else begin
        av_waitrequest = 1'b1;
        stall = 0;
      end
    end
  end

  // Bus monitor: accepted reads and stability while stalled
  always @(posedge clock) begin
    if (reset === 1'b1) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall && done !== 1'b1 &&
          (av_read !== 1'b1 || av_address !== prev_addr))
        viol <= viol + 1;
      prev_stall <= av_read && av_waitrequest;
      prev_addr <= av_address;
      if (av_read === 1'b1 && av_waitrequest === 1'b0)
        acc_q.push_back(int'(av_address));
    end
  end

  always @(negedge clock) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  // Reference: each word costs stall+1+delay cycles unless that exceeds
  // the per-word budget of T cycles, in which case the probe aborts.
  task automatic predict();
    logic cap[2];
    exp_off = 0;
    exp_acc = 0;
    exp_to = 1'b0;
    cap[0] = 1'b0;
    cap[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (cfg_w[k] <= T - 1) exp_acc++;
      if (cfg_d[k] < 0 || cfg_w[k] + cfg_d[k] > T - 1) begin
        exp_off += T;
        exp_to = 1'b1;
        break;
      end
      exp_off += cfg_w[k] + 1 + cfg_d[k];
      cap[k] = 1'b1;
    end
    exp_id = cap[0] ? cfg_word[0] : 32'd0;
    exp_ts = cap[1] ? cfg_word[1] : 32'd0;
    exp_idm = !exp_to && (cfg_word[0] == EXP_ID);
    exp_tsm = !exp_to && (cfg_word[1] == EXP_TS);
  endtask

  task automatic setup(input int w0, input int d0, input logic [31:0] v0,
                       input int w1, input int d1, input logic [31:0] v1);
    cfg_w[0] = w0;
    cfg_d[0] = d0;
    cfg_word[0] = v0;
    cfg_w[1] = w1;
    cfg_d[1] = d1;
    cfg_word[1] = v1;
  endtask

  task automatic run_probe(input string tag);
    int n;
    int acc0;
    predict();
    acc0 = acc_q.size();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n = 0;
    check({tag, ":busy_start"}, 32'(busy), 32'd1);
    while (done !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    check({tag, ":latency"}, n, exp_off);
    check({tag, ":id_value"}, id_value, exp_id);
    check({tag, ":ts_value"}, ts_value, exp_ts);
    check({tag, ":id_match"}, 32'(id_match), 32'(exp_idm));
    check({tag, ":ts_match"}, 32'(ts_match), 32'(exp_tsm));
    check({tag, ":timeout"}, 32'(timeout), 32'(exp_to));
    check({tag, ":accepts"}, acc_q.size() - acc0, exp_acc);
    for (int i = acc0; i < acc_q.size(); i++)
      check({tag, ":addr_order"}, acc_q[i], i - acc0);
    @(negedge clock);
    check({tag, ":done_pulse"}, 32'(done), 32'd0);
    check({tag, ":busy_end"}, 32'(busy), 32'd0);
    check({tag, ":held"}, 32'(timeout), 32'(exp_to));
    repeat (25) @(negedge clock);
  endtask

  initial begin
    int dc0;
    int acc0;
    reset = 1'b1;
    start = 1'b0;
    setup(0, 1, EXP_ID, 0, 1, EXP_TS);
    repeat (3) @(negedge clock);
    check("rst:av_read", 32'(av_read), 32'd0);
    check("rst:av_address", 32'(av_address), 32'd0);
    check("rst:busy", 32'(busy), 32'd0);
    check("rst:done", 32'(done), 32'd0);
    check("rst:id_value", id_value, 32'd0);
    check("rst:ts_value", ts_value, 32'd0);
    check("rst:flags", {29'd0, id_match, ts_match, timeout}, 32'd0);
    reset = 1'b0;

    setup(0, 1, EXP_ID, 0, 1, EXP_TS);
    run_probe("zero_wait");
    setup(0, 0, EXP_ID, 0, 0, EXP_TS);
    run_probe("same_cycle");
    setup(0, 1, EXP_ID, 0, 1, 32'd1537788543);
    run_probe("ts_bad");
    setup(0, 1, 32'h1234_5678, 0, 1, EXP_TS);
    run_probe("id_bad");
    setup(3, 2, EXP_ID, 3, 2, EXP_TS);
    run_probe("stalled");
    setup(0, 1, EXP_ID, 0, -1, EXP_TS);
    run_probe("ts_timeout");
    setup(10, 5, EXP_ID, 10, 5, EXP_TS);
    run_probe("edge_ok");
    setup(0, 1, EXP_ID, 10, 6, EXP_TS);
    run_probe("edge_to");
    setup(15, 1, EXP_ID, 0, 1, EXP_TS);
    run_probe("accept_last");
    setup(16, 0, EXP_ID, 0, 1, EXP_TS);
    run_probe("stall_to");

    for (int r = 0; r < 8; r++) begin
      setup($urandom_range(0, 4), $urandom_range(0, 4),
            $urandom_range(0, 1) ? EXP_ID : $urandom(),
            $urandom_range(0, 4), $urandom_range(0, 4),
            $urandom_range(0, 1) ? EXP_TS : $urandom());
      run_probe($sformatf("rand%0d", r));
    end

    setup(0, 8, EXP_ID, 0, 1, EXP_TS);
    dc0 = done_cnt;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midrst:av_read", 32'(av_read), 32'd0);
    check("midrst:busy", 32'(busy), 32'd0);
    check("midrst:done", 32'(done), 32'd0);
    check("midrst:id_value", id_value, 32'd0);
    repeat (15) @(negedge clock);
    check("midrst:no_done", done_cnt - dc0, 0);
    check("midrst:stray_id", id_value, 32'd0);
    check("midrst:idle", 32'(busy), 32'd0);

    setup(3, 2, EXP_ID, 3, 2, EXP_TS);
    dc0 = done_cnt;
    acc0 = acc_q.size();
    @(negedge clock);
    start = 1'b1;
    repeat (10) @(negedge clock);
    start = 1'b0;
    repeat (30) @(negedge clock);
    check("held_start:dones", done_cnt - dc0, 1);
    check("held_start:accepts", acc_q.size() - acc0, 2);
    check("held_start:match", {30'd0, id_match, ts_match}, 32'd3);

    check("stall_stable", viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
